// File: rtl/lcdi_edge_interp.sv
// Edge-directed line averaging (ELA) interpolator: one output pixel per accepted
// 3+3 pixel window, through a fixed 3-stage pipeline with a per-line column counter.
module lcdi_edge_interp #(
    parameter int          DATA_WIDTH = 8,
    parameter int          LINE_W     = 64,
    parameter int unsigned EDGE_TH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] index_data0,
    input  logic [DATA_WIDTH-1:0] index_data1,
    input  logic [DATA_WIDTH-1:0] index_data2,
    input  logic [DATA_WIDTH-1:0] inter_data0,
    input  logic [DATA_WIDTH-1:0] inter_data1,
    input  logic [DATA_WIDTH-1:0] inter_data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic [1:0]            dir_out,
    output logic                  out_last
);

    localparam int            CW        = $clog2(LINE_W);
    localparam logic [CW-1:0] LAST_COL  = CW'(LINE_W - 1);
    localparam logic [1:0]    DIR_CTR   = 2'd0;
    localparam logic [1:0]    DIR_LEFT  = 2'd1;
    localparam logic [1:0]    DIR_RIGHT = 2'd2;

    function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Handshake: a beat moves when valid & ready are both high at a rising edge.
    // The whole pipe shifts on advance; ready upstream is advance itself, so a
    // stalled output freezes every stage (no bubble collapsing).
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_dl, s1_dc, s1_dr;
    logic [DATA_WIDTH:0]   s1_sl, s1_sc, s1_sr;
    logic                  s2_valid;
    logic [1:0]            s2_dir;
    logic [DATA_WIDTH:0]   s2_sum;
    logic [1:0]            sel_dir;
    logic [DATA_WIDTH:0]   sel_sum;
    logic [CW-1:0]         col_cnt;

    // Priority: small centre difference, then minimum difference; ties go centre, then left.
    always_comb begin
        sel_dir = DIR_RIGHT;
        sel_sum = s1_sr;
        if ((32'(s1_dc) < EDGE_TH) || ((s1_dc <= s1_dl) && (s1_dc <= s1_dr))) begin
            sel_dir = DIR_CTR;
            sel_sum = s1_sc;
        end else if (s1_dl <= s1_dr) begin
            sel_dir = DIR_LEFT;
            sel_sum = s1_sl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_dl     <= '0;
            s1_dc     <= '0;
            s1_dr     <= '0;
            s1_sl     <= '0;
            s1_sc     <= '0;
            s1_sr     <= '0;
            s2_valid  <= 1'b0;
            s2_dir    <= DIR_CTR;
            s2_sum    <= '0;
            out_valid <= 1'b0;
            pix_out   <= '0;
            dir_out   <= DIR_CTR;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_dl     <= abs_diff(index_data0, inter_data2);
            s1_dc     <= abs_diff(index_data1, inter_data1);
            s1_dr     <= abs_diff(index_data2, inter_data0);
            s1_sl     <= {1'b0, index_data0} + {1'b0, inter_data2};
            s1_sc     <= {1'b0, index_data1} + {1'b0, inter_data1};
            s1_sr     <= {1'b0, index_data2} + {1'b0, inter_data0};
            s2_valid  <= s1_valid;
            s2_dir    <= sel_dir;
            s2_sum    <= sel_sum;
            out_valid <= s2_valid;
            // (sum + 1) >> 1 written as floor(sum/2) + lsb; cannot exceed DATA_WIDTH bits.
            pix_out   <= s2_sum[DATA_WIDTH:1] + DATA_WIDTH'(s2_sum[0]);
            dir_out   <= s2_dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
        end else if (out_valid && out_ready) begin
            col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
        end
    end

    assign out_last = out_valid & (col_cnt == LAST_COL);

endmodule
